latch_bank: RTL
===============

Name: latch_bank

Overview:
- Multi-channel, parametrised capture bank; successor of the single-channel enable-gated 4-bit holding register.
- Each channel holds its last enabled sample in flops; there are no latches.
- Held values are exported in parallel.
- A round-robin readout engine streams changed channels out over a valid/ready handshake, with per-channel dirty and overrun status.
- Sits between per-channel producers and a single status/telemetry consumer.

Parameters:
- WIDTH, 4, bits per channel value (>=1)
- CHANNELS, 4, number of channels (>=2)
- CH_W, $clog2(CHANNELS), width of channel index (localparam-derived, not overridable)

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  synchronous reset, active-high
- i_en  input  CHANNELS  per-channel capture enable
- i_a  input  CHANNELS*WIDTH  per-channel sample; channel k at [k*WIDTH +: WIDTH]
- o_a  output  CHANNELS*WIDTH  held value of every channel, same packing
- o_dirty  output  CHANNELS  channel captured since last readout
- o_overrun  output  CHANNELS  sticky: capture overwrote an unread dirty value
- i_ovr_clr  input  1  clears all o_overrun bits
- o_valid  output  1  readout word valid
- i_ready  input  1  consumer accepts readout word
- o_ch  output  CH_W  channel index of readout word
- o_data  output  WIDTH  snapshot value of readout word

Behaviour:
- Reset: o_a, o_dirty, o_overrun, o_valid, o_ch, o_data all 0; FSM=S_IDLE; rr pointer=0. Reset wins over every other event.
- Capture: if i_en[k], held[k] <= i_a slice next edge; o_a updates 1 cycle after the enable. Channels are independent; any subset may capture in the same cycle.
- Dirty set: a capture on k sets dirty[k] (see Optional Feature).
- Overrun: dirty-setting capture while dirty[k]=1 sets overrun[k]. i_ovr_clr clears all bits; a set in the same cycle wins over the clear.
- FSM S_IDLE:
  - If any dirty, pick the first dirty channel searching from pointer upward, wrapping at CHANNELS-1 -> 0.
  - Next edge: o_ch<=k, o_data<=held[k] (registered value, not i_a), dirty[k]<=0, o_valid<=1, pointer<=(k+1) mod CHANNELS, go to S_OFFER.
  - No dirty -> stay.
- FSM S_OFFER:
  - o_valid, o_ch, o_data stable until i_ready.
  - valid&ready -> o_valid<=0, S_IDLE.
  - o_valid must not drop without ready.
- Simultaneous capture on k on the grant edge: dirty[k] ends 1 (set beats clear); o_data holds the pre-capture value; no overrun.
- Throughput: max one word per 2 cycles (IDLE bubble). Grant latency: dirty visible -> o_valid 1 cycle.
- i_ready while o_valid=0: ignored.

Optional Feature:
- Macro LATCH_BANK_CHANGE_ONLY_EN.
- Defined: a capture sets dirty[k] (and may set overrun) only if i_a slice != held[k]; the held value still updates.
- Undefined: every enabled capture sets dirty[k], even when the value is unchanged.

Decomposition:
- Package latch_bank_pkg:
  - state enum {S_IDLE, S_OFFER} (typedef state_t)
  - function for round-robin next-index wrap
- Sub-module rr_pick:
  - combinational find-first-set from pointer with wrap
  - params CHANNELS; ports i_req[CHANNELS], i_ptr[CH_W], o_any, o_idx[CH_W]
  - instantiated once in latch_bank

Test Plan:
- Reset hold 3 cycles, release -> o_a=0, o_dirty=0, o_valid=0; no output activity with i_en=0.
- WIDTH=4, CHANNELS=4: i_en=0010, ch1=4'hA, i_ready=1 -> o_a[7:4]=A at +1; o_valid=1, o_ch=1, o_data=A at +2; o_dirty=0 after grant.
- i_en=1111 once with values 1,2,3,4, i_ready=1 -> words ch0..ch3 in order, one every 2 cycles; pointer wraps back to 0.
- ch2 captures 5 then 6 while i_ready=0 with a word pending on ch0 -> overrun[2]=1; after ready, ch2 word carries 6; i_ovr_clr pulse -> overrun=0.
- Capture on ch0 exactly on its grant edge -> o_data = old value; dirty[0]=1; a second ch0 word follows with the new value.
- Mid-offer reset (o_valid=1, i_ready=0) -> next cycle all outputs 0, S_IDLE. With LATCH_BANK_CHANGE_ONLY_EN, a re-capture of an identical value -> no dirty, no word emitted.

Source files
------------

// File: rtl/latch_bank_pkg.sv
// rtl/latch_bank_pkg.sv - shared types and helpers for the latch_bank capture bank
package latch_bank_pkg;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_OFFER = 1'b1
   } state_t;

   // Round-robin successor of idx in a ring of n entries.
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/latch_bank_rr_pick.sv
// rtl/latch_bank_rr_pick.sv - combinational find-first-set starting at a pointer, wrapping
module rr_pick #(
   parameter  int CHANNELS = 4,
   localparam int CH_W     = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] i_req,
   input  logic [CH_W-1:0]     i_ptr,
   output logic                o_any,
   output logic [CH_W-1:0]     o_idx
);

   int j;

   always_comb begin
      o_any = 1'b0;
      o_idx = '0;
      j     = 0;
      for (int i = 0; i < CHANNELS; i++) begin
         j = (int'(i_ptr) + i) % CHANNELS;
         if (!o_any && i_req[j]) begin
            o_any = 1'b1;
            o_idx = CH_W'(j);
         end
      end
   end

endmodule

// File: rtl/latch_bank.sv
// rtl/latch_bank.sv - multi-channel capture bank with round-robin readout of changed channels
// Optional: LATCH_BANK_CHANGE_ONLY_EN makes only value-changing captures mark a channel dirty.
module latch_bank
   import latch_bank_pkg::*;
#(
   parameter  int WIDTH    = 4,
   parameter  int CHANNELS = 4,
   localparam int CH_W     = $clog2(CHANNELS)
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [CHANNELS-1:0]       i_en,
   input  logic [CHANNELS*WIDTH-1:0] i_a,
   output logic [CHANNELS*WIDTH-1:0] o_a,
   output logic [CHANNELS-1:0]       o_dirty,
   output logic [CHANNELS-1:0]       o_overrun,
   input  logic                      i_ovr_clr,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [CH_W-1:0]           o_ch,
   output logic [WIDTH-1:0]          o_data
);

   logic [CHANNELS-1:0][WIDTH-1:0] held_q, held_d;
   logic [CHANNELS-1:0]            dirty_q, dirty_d;
   logic [CHANNELS-1:0]            ovr_q, ovr_d;
   logic [CHANNELS-1:0]            cap, gmask;
   logic [CH_W-1:0]                ptr_q, ch_q, pick_idx;
   logic [WIDTH-1:0]               data_q;
   logic                           valid_q, pick_any, grant;
   state_t                         state_q;

   rr_pick #(.CHANNELS(CHANNELS)) u_pick (
      .i_req (dirty_q),
      .i_ptr (ptr_q),
      .o_any (pick_any),
      .o_idx (pick_idx)
   );

   always_comb begin
      cap    = '0;
      held_d = held_q;
      for (int k = 0; k < CHANNELS; k++) begin
`ifdef LATCH_BANK_CHANGE_ONLY_EN
         cap[k] = i_en[k] && (i_a[k*WIDTH +: WIDTH] != held_q[k]);
`else
         cap[k] = i_en[k];
`endif
         if (i_en[k]) held_d[k] = i_a[k*WIDTH +: WIDTH];
      end
      grant = (state_q == S_IDLE) && pick_any;
      gmask = grant ? (CHANNELS'(1) << pick_idx) : '0;
      // A capture on the channel being granted re-dirties it without counting as overrun.
      dirty_d = (dirty_q & ~gmask) | cap;
      ovr_d   = (i_ovr_clr ? '0 : ovr_q) | (cap & dirty_q & ~gmask);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         held_q  <= '0;
         dirty_q <= '0;
         ovr_q   <= '0;
         ptr_q   <= '0;
         ch_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         state_q <= S_IDLE;
      end else begin
         held_q  <= held_d;
         dirty_q <= dirty_d;
         ovr_q   <= ovr_d;
         case (state_q)
            S_IDLE: begin
               if (grant) begin
                  ch_q    <= pick_idx;
                  data_q  <= held_q[pick_idx];
                  valid_q <= 1'b1;
                  ptr_q   <= CH_W'(rr_next(int'(pick_idx), CHANNELS));
                  state_q <= S_OFFER;
               end
            end
            S_OFFER: begin
               if (i_ready) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_a       = held_q;
   assign o_dirty   = dirty_q;
   assign o_overrun = ovr_q;
   assign o_valid   = valid_q;
   assign o_ch      = ch_q;
   assign o_data    = data_q;

endmodule
